// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and the arbiter.
// Loads wait behind queued stores, then pass straight through.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_en,
   input  logic [3:0]       cpu_write_en,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_write_data,
   output logic [31:0]      cpu_read_data,
   output logic             cpu_stall,
   output logic             mem_en,
   output logic [3:0]       mem_write_en,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_write_data,
   input  logic [31:0]      mem_read_data,
   input  logic             mem_busy,
   output logic [PTR_W:0]   buf_count,
   output logic             buf_empty
);

   localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [31:0]      r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [3:0]       r_strb [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_store;
   logic w_load_req;
   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_load;

   assign w_store    = cpu_en & (|cpu_write_en);
   assign w_load_req = cpu_en & ~(|cpu_write_en);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL);
   // A full buffer refuses the push even if the head pops this cycle
   assign w_push     = w_store & ~w_full;
   assign w_pop      = ~w_empty & ~mem_busy;
   assign w_load     = w_load_req & w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= cpu_addr;
         r_data[r_wr_ptr] <= cpu_write_data;
         r_strb[r_wr_ptr] <= cpu_write_en;
      end
   end

   always_comb begin
      mem_en         = 1'b0;
      mem_write_en   = 4'h0;
      mem_addr       = 32'h0;
      mem_write_data = 32'h0;
      cpu_read_data  = 32'h0;
      if (!w_empty) begin
         mem_en         = 1'b1;
         mem_write_en   = r_strb[r_rd_ptr];
         mem_addr       = r_addr[r_rd_ptr];
         mem_write_data = r_data[r_rd_ptr];
      end else if (w_load) begin
         mem_en        = 1'b1;
         mem_addr      = cpu_addr;
         cpu_read_data = mem_read_data;
      end
   end

   assign cpu_stall = (w_store & w_full)
                    | (w_load_req & (~w_empty | mem_busy));
   assign buf_count = r_count;
   assign buf_empty = w_empty;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, posted stores, full,
// load ordering, empty-buffer load and pointer wrap.
module tb_store_buffer;

   logic        clk;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_write_en;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        cpu_stall;
   logic        mem_en;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_busy;
   logic [2:0]  buf_count;
   logic        buf_empty;

   int checks = 0;
   int errors = 0;

   store_buffer #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_en         (cpu_en),
      .cpu_write_en   (cpu_write_en),
      .cpu_addr       (cpu_addr),
      .cpu_write_data (cpu_write_data),
      .cpu_read_data  (cpu_read_data),
      .cpu_stall      (cpu_stall),
      .mem_en         (mem_en),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_busy       (mem_busy),
      .buf_count      (buf_count),
      .buf_empty      (buf_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic en, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] d);
      cpu_en         = en;
      cpu_write_en   = we;
      cpu_addr       = a;
      cpu_write_data = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_busy = 1'b0;
      mem_read_data = 32'h5555_AAAA;
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++;
      if (buf_count !== 3'd0) begin
         errors++; $display("FAIL rst_count got %0d exp 0", buf_count);
      end
      checks++;
      if (buf_empty !== 1'b1) begin
         errors++; $display("FAIL rst_empty got %b exp 1", buf_empty);
      end
      checks++;
      if ({mem_en, mem_write_en, mem_addr, mem_write_data} !== 69'h0) begin
         errors++;
         $display("FAIL rst_mem got en=%b we=%h a=%h d=%h exp all 0",
                  mem_en, mem_write_en, mem_addr, mem_write_data);
      end
      checks++;
      if ({cpu_stall, cpu_read_data} !== 33'h0) begin
         errors++;
         $display("FAIL rst_cpu got stall=%b rd=%h exp 0/0",
                  cpu_stall, cpu_read_data);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'hF, 32'(32'h600 + 4*i), 32'(32'hE0 + i));
         @(negedge clk);
      end
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++;
      if (buf_count !== 3'd3) begin
         errors++; $display("FAIL mid_count got %0d exp 3", buf_count);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h600) begin
         errors++;
         $display("FAIL mid_head got en=%b a=%h exp 1/600", mem_en, mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (buf_count !== 3'd0 || buf_empty !== 1'b1) begin
         errors++;
         $display("FAIL async_rst got cnt=%0d empty=%b exp 0/1",
                  buf_count, buf_empty);
      end
      checks++;
      if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL async_rst_mem got en=%b a=%h exp 0/0", mem_en, mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_busy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (mem_en !== 1'b0 || buf_count !== 3'd0) begin
            errors++;
            $display("FAIL stale_write c%0d got en=%b cnt=%0d exp 0/0",
                     c, mem_en, buf_count);
         end
      end
   endtask

   task automatic test_posted();
      logic [31:0] ea;
      logic [31:0] ed;
      mem_busy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < 4) drive(1'b1, 4'hF, 32'(32'h100 + 4*c), 32'(32'hA0 + c));
         else       drive(1'b0, 4'h0, 32'h0, 32'h0);
         #1;
         checks++;
         if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL posted_stall c%0d got %b exp 0", c, cpu_stall);
         end
         checks++;
         if (c >= 1 && c <= 4) begin
            ea = 32'(32'h100 + 4*(c-1));
            ed = 32'(32'hA0 + c - 1);
            if (mem_en !== 1'b1 || mem_write_en !== 4'hF ||
                mem_addr !== ea || mem_write_data !== ed) begin
               errors++;
               $display("FAIL posted_mem c%0d got en=%b we=%h a=%h d=%h exp 1/f/%h/%h",
                        c, mem_en, mem_write_en, mem_addr, mem_write_data, ea, ed);
            end
         end else if (mem_en !== 1'b0) begin
            errors++; $display("FAIL posted_idle c%0d got en=%b exp 0", c, mem_en);
         end
      end
   endtask

   task automatic test_full();
      logic [31:0] ea;
      mem_busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 4'hF, 32'(32'h400 + 4*c), 32'(32'hB0 + c));
         #1;
         checks++;
         if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL full_fill c%0d got stall=%b exp 0", c, cpu_stall);
         end
      end
      @(negedge clk);
      drive(1'b1, 4'hF, 32'h410, 32'hB4);
      #1;
      checks++;
      if (cpu_stall !== 1'b1 || buf_count !== 3'd4) begin
         errors++;
         $display("FAIL full_stall got stall=%b cnt=%0d exp 1/4", cpu_stall, buf_count);
      end
      @(negedge clk);
      mem_busy = 1'b0;
      #1;
      checks++;
      if (cpu_stall !== 1'b1 || mem_addr !== 32'h400) begin
         errors++;
         $display("FAIL full_popcycle got stall=%b a=%h exp 1/400", cpu_stall, mem_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || buf_count !== 3'd3 || mem_addr !== 32'h404) begin
         errors++;
         $display("FAIL full_accept got stall=%b cnt=%0d a=%h exp 0/3/404",
                  cpu_stall, buf_count, mem_addr);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b0, 4'h0, 32'h0, 32'h0);
         #1;
         checks++;
         if (c < 3) begin
            ea = 32'(32'h408 + 4*c);
            if (mem_en !== 1'b1 || mem_addr !== ea ||
                mem_write_data !== 32'(32'hB2 + c)) begin
               errors++;
               $display("FAIL full_drain c%0d got en=%b a=%h d=%h exp 1/%h/%h",
                        c, mem_en, mem_addr, mem_write_data, ea, 32'(32'hB2 + c));
            end
         end else if (mem_en !== 1'b0 || buf_count !== 3'd0) begin
            errors++;
            $display("FAIL full_end got en=%b cnt=%0d exp 0/0", mem_en, buf_count);
         end
      end
   endtask

   task automatic test_load_order();
      mem_busy = 1'b0;
      mem_read_data = 32'h1234_5678;
      @(negedge clk);
      drive(1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL lo_store got stall=%b en=%b exp 0/0", cpu_stall, mem_en);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         mem_busy = (c == 0);
         drive(1'b1, 4'h0, 32'h200, 32'h0);
         #1;
         checks++;
         if (cpu_stall !== 1'b1 || mem_write_en !== 4'hF ||
             mem_addr !== 32'h200 || mem_write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lo_wait c%0d got stall=%b we=%h a=%h d=%h exp 1/f/200/deadbeef",
                     c, cpu_stall, mem_write_en, mem_addr, mem_write_data);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_write_en !== 4'h0 ||
          mem_addr !== 32'h200 || mem_write_data !== 32'h0) begin
         errors++;
         $display("FAIL lo_issue got stall=%b en=%b we=%h a=%h d=%h exp 0/1/0/200/0",
                  cpu_stall, mem_en, mem_write_en, mem_addr, mem_write_data);
      end
      checks++;
      if (cpu_read_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL lo_data got %h exp 12345678", cpu_read_data);
      end
   endtask

   task automatic test_empty_load();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         mem_busy = (c < 2);
         mem_read_data = 32'(32'hCAFE_F00D + c);
         drive(1'b1, 4'h0, 32'h300, 32'h0);
         #1;
         checks++;
         if (cpu_stall !== (c < 2) || mem_en !== 1'b1 || mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL el_c%0d got stall=%b en=%b a=%h exp %b/1/300",
                     c, cpu_stall, mem_en, mem_addr, (c < 2));
         end
      end
      checks++;
      if (cpu_read_data !== 32'hCAFE_F00F) begin
         errors++; $display("FAIL el_data got %h exp cafef00f", cpu_read_data);
      end
      @(negedge clk);
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++;
      if (cpu_read_data !== 32'h0 || mem_en !== 1'b0 || cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL el_idle got rd=%h en=%b stall=%b exp 0/0/0",
                  cpu_read_data, mem_en, cpu_stall);
      end
   endtask

   task automatic test_wrap();
      int i = 0;
      int k = 0;
      int cnt = 0;
      logic push;
      logic pop;
      for (int c = 0; c < 80 && k < 10; c++) begin
         @(negedge clk);
         mem_busy = (c % 2 == 0);
         if (i < 10) drive(1'b1, 4'(i + 1), 32'(32'h500 + 4*i), 32'(32'hC0 + i));
         else        drive(1'b0, 4'h0, 32'h0, 32'h0);
         #1;
         checks++;
         if (buf_count !== 3'(cnt)) begin
            errors++; $display("FAIL wrap_count c%0d got %0d exp %0d", c, buf_count, cnt);
         end
         checks++;
         if (cpu_stall !== (i < 10 && cnt == 4)) begin
            errors++;
            $display("FAIL wrap_stall c%0d got %b exp %b", c, cpu_stall, (i < 10 && cnt == 4));
         end
         if (cnt > 0) begin
            checks++;
            if (mem_en !== 1'b1 || mem_write_en !== 4'(k + 1) ||
                mem_addr !== 32'(32'h500 + 4*k) || mem_write_data !== 32'(32'hC0 + k)) begin
               errors++;
               $display("FAIL wrap_mem c%0d got en=%b we=%h a=%h d=%h exp entry %0d",
                        c, mem_en, mem_write_en, mem_addr, mem_write_data, k);
            end
         end
         push = (i < 10) && (cnt < 4);
         pop  = (cnt > 0) && !mem_busy;
         if (push) i++;
         if (pop) k++;
         cnt = cnt + int'(push) - int'(pop);
      end
      checks++;
      if (k != 10) begin
         errors++; $display("FAIL wrap_done got %0d writes exp 10", k);
      end
      @(negedge clk);
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++;
      if (mem_en !== 1'b0 || buf_empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_idle got en=%b empty=%b exp 0/1", mem_en, buf_empty);
      end
   endtask

   initial begin
      test_reset();
      test_posted();
      test_full();
      test_load_order();
      test_empty_load();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the Uranus core's data-RAM port (`ram_*`) and the Arbiter's RAM-side port. Stores are queued in a small FIFO and drained to the Arbiter in the background, so the core does not stall on each AXI write. Loads are ordered behind every queued store: a load waits until the FIFO is empty, then passes straight through to the Arbiter. Reads and writes to the same address, including MMIO, therefore always occur in program order.

## Interface
Parameters:
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`, pointer width. The count register is `PTR_W+1` bits wide.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_en` in 1: core data request.
- `cpu_write_en` in 4: byte strobes; non-zero means store, zero means load.
- `cpu_addr` in 32: byte address.
- `cpu_write_data` in 32: store data.
- `cpu_read_data` out 32: load data.
- `cpu_stall` out 1: core must hold its request and pipeline.
- `mem_en` out 1: request to the Arbiter.
- `mem_write_en` out 4: byte strobes to the Arbiter.
- `mem_addr` out 32: address to the Arbiter.
- `mem_write_data` out 32: write data to the Arbiter.
- `mem_read_data` in 32: read data from the Arbiter.
- `mem_busy` in 1: Arbiter stall. A transfer completes in any cycle with `mem_en=1` and `mem_busy=0`.
- `buf_count` out `PTR_W+1`: number of occupied entries.
- `buf_empty` out 1: `buf_count==0`.

## Operation
- Entry format: {addr[31:0], data[31:0], strb[3:0]}. Storage is `DEPTH` registers, with `wr_ptr`, `rd_ptr` and `count` registers. Pointers wrap modulo `DEPTH` (natural `PTR_W`-bit overflow).
- Store accept:
  - Condition: `cpu_en && |cpu_write_en && count<DEPTH`.
  - On accept, write the entry at `wr_ptr` and increment `wr_ptr`. `cpu_stall=0`.
  - When `count==DEPTH`: `cpu_stall=1`. No push happens, even if a pop occurs in the same cycle; the store is accepted the following cycle.
- Drain:
  - While `count>0`, the mem port shows the entry at `rd_ptr`: `mem_en=1`, `mem_write_en=strb`, `mem_addr=addr`, `mem_write_data=data`.
  - Pop (increment `rd_ptr`) on each edge where `mem_busy=0`.
- Load:
  - Condition: `cpu_en && cpu_write_en==0`.
  - If `count>0`: `cpu_stall=1`. Drain continues; the load is not forwarded to the mem port.
  - If `count==0`: pass through. `mem_en=1`, `mem_write_en=0`, `mem_addr=cpu_addr`, `mem_write_data=0`, `cpu_stall=mem_busy`, `cpu_read_data=mem_read_data`.
  - No store-to-load forwarding.
- Idle: `count==0` and no load → `mem_en=0`, and all other mem outputs are 0.
- Count update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- A store to an address already in the buffer is queued as a separate entry; there is no merging.
- `cpu_en=0` → `cpu_stall=0`. `cpu_read_data` is `mem_read_data` whenever a load is passing through; otherwise it is 0.

## Timing
- Reset, asynchronous and effective immediately:
  - `wr_ptr=rd_ptr=count=0`; all queued stores are discarded.
  - Outputs: `mem_en=0`, `mem_write_en=0`, `mem_addr=0`, `mem_write_data=0`, `cpu_stall=0` (while `cpu_en=0`), `cpu_read_data=0`, `buf_count=0`, `buf_empty=1`.
  - Entry storage does not need a reset.
- Store latency: a store accepted at edge N appears on the mem port at cycle N+1 at the earliest. The mem port is driven from registered state; there is no bypass from `cpu_*` for stores.
- Drain throughput: one entry per cycle while `mem_busy=0`.
- Load latency:
  - Empty buffer: combinational; data returns in the first cycle with `mem_busy=0`.
  - Non-empty buffer: stall cycles = drain time + Arbiter latency.
- `cpu_stall` is combinational from `cpu_en`, `cpu_write_en`, `count` and `mem_busy`.
- The mem outputs must be stable while `mem_busy=1`: the head entry does not change until it is popped.
- No combinational path from `mem_busy` to `mem_en`.

## Test plan
- **Reset:** assert `rst` mid-drain with count=3 → `buf_count=0`, `mem_en=0` immediately; after deassert, no stale write reaches the mem port.
- **Posted stores:** 4 back-to-back stores (addr 0x100..0x10C, data 0xA0..0xA3, strb 0xF) with `mem_busy=0` → `cpu_stall=0` throughout; mem port shows the same four writes in order at cycles 1–4, then `mem_en=0`.
- **Full:** hold `mem_busy=1` and issue 5 stores with DEPTH=4 → 5th store sees `cpu_stall=1`. It stays stalled through the cycle `mem_busy` drops (pop cycle), is accepted one cycle later, and is written last.
- **Load ordering:** store 0xDEADBEEF to 0x200, then immediately load 0x200 → `cpu_stall=1` until the store's mem transfer completes; the load then issues with `mem_write_en=0`, `mem_addr=0x200`, and returns `mem_read_data`.
- **Empty-buffer load:** count=0, load 0x300, `mem_busy=1` for 2 cycles → `cpu_stall=1` for exactly 2 cycles; `cpu_read_data` equals `mem_read_data` in the third cycle.
- **Wrap-around and simultaneous push/pop:** issue 10 stores while `mem_busy` toggles 1/0 → `buf_count` stays unchanged on cycles with both a push and a pop; pointers wrap past DEPTH; all 10 writes appear on the mem port in order, with their strobes intact.
